shift_out_driver: RTL and testbench
===================================

SHIFT_OUT_DRIVER -- requirements
Module: shift_out_driver

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving bits per channel per frame (legal: DATA_W >= 2).
REQ-002 The module SHALL have parameter CHANNELS, default 1, giving the number of parallel serial data lanes sharing one shift clock and latch (legal: 1..8).
REQ-003 The module SHALL have parameter CLK_DIV, default 4, giving the o_SCLK half-period in i_CLK cycles (legal: >= 1).
REQ-004 The module SHALL have parameter MSB_FIRST, default 1, where 1 shifts bit DATA_W-1 first and 0 shifts bit 0 first.
REQ-005 The module SHALL have parameter LATCH_CYCLES, default 2, giving the o_Latch high width in i_CLK cycles (legal: >= 1).
REQ-006 i_CLK  input  1  system clock; all logic on rising edge.
REQ-007 i_RESET  input  1  reset, asynchronous, active-high.
REQ-008 i_Data  input  CHANNELS*DATA_W  frame data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 i_Load  input  1  start-frame request, sampled only in IDLE.
REQ-010 i_AutoRefresh  input  1  when high, a new frame starts automatically each time IDLE is entered.
REQ-011 o_SData  output  CHANNELS  serial data, one bit per lane.
REQ-012 o_SCLK  output  1  shift clock; downstream samples on rising edge.
REQ-013 o_Latch  output  1  commit strobe, active-high.
REQ-014 o_Busy  output  1  high while in SHIFT or LATCH.
REQ-015 o_Done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, LATCH; IDLE -> SHIFT on i_Load or i_AutoRefresh; SHIFT -> LATCH after the last bit period; LATCH -> IDLE after LATCH_CYCLES cycles.
REQ-017 On the IDLE-to-SHIFT edge, all of i_Data SHALL be captured into an internal shadow register; later i_Data changes do not affect the frame in progress.
REQ-018 Each bit period SHALL be 2*CLK_DIV cycles: o_SCLK low for the first CLK_DIV cycles, high for the next CLK_DIV cycles, with o_SData stable for the whole period.
REQ-019 The first bit SHALL appear on o_SData in the cycle after the start request is accepted; SHIFT SHALL last exactly DATA_W*2*CLK_DIV cycles.
REQ-020 All lanes SHALL shift the same bit index in the same cycle in the order given by MSB_FIRST.
REQ-021 In LATCH, o_SCLK SHALL be 0, o_SData SHALL hold the last bit, and o_Latch SHALL be 1 for exactly LATCH_CYCLES cycles.
REQ-022 o_Done SHALL pulse high for one cycle in the first IDLE cycle after LATCH; the total from accept to o_Done SHALL be DATA_W*2*CLK_DIV + LATCH_CYCLES + 1 cycles.
REQ-023 i_Load while o_Busy=1 SHALL be ignored and not queued.
REQ-024 i_Load and i_AutoRefresh both high in IDLE SHALL start exactly one frame.
REQ-025 With i_AutoRefresh held high, a new frame SHALL be accepted in the o_Done cycle, so consecutive frames are separated by exactly one IDLE cycle.
REQ-026 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and the divider counter ceil(log2(CLK_DIV+1)) bits wide; neither SHALL wrap within a frame.
REQ-027 In IDLE, o_SCLK, o_Latch, and o_Busy SHALL be 0 and o_SData SHALL be 0.

Reset
REQ-028 While i_RESET=1, the state SHALL be IDLE and o_SData, o_SCLK, o_Latch, o_Busy, o_Done SHALL be 0, regardless of i_CLK.
REQ-029 Reset asserted mid-SHIFT or mid-LATCH SHALL abort the frame immediately without any further o_Latch pulse, so downstream registers keep their previous contents.
REQ-030 After reset deasserts, the first frame SHALL start only on a subsequent i_Load or i_AutoRefresh.

Verification
REQ-031 DATA_W=16, CHANNELS=1, CLK_DIV=2, i_Data=16'h0300, single i_Load pulse -> bits sampled on o_SCLK rises are 0000_0011_0000_0000; SHIFT lasts 64 cycles; o_Latch high for 2 cycles; o_Done on cycle 67 after accept.
REQ-032 MSB_FIRST=0, i_Data=16'h0001 -> first sampled bit is 1 and the remaining 15 are 0.
REQ-033 CHANNELS=2, i_Data=32'hA5A5_0F0F -> lane0 shifts 0x0F0F and lane1 shifts 0xA5A5 on the same o_SCLK edges.
REQ-034 i_Load pulsed at cycle 10 of a frame and i_Data changed mid-frame -> no second frame, and the shifted data equals the captured value.
REQ-035 i_AutoRefresh held high for 3 frames -> three o_Done pulses with exactly one IDLE cycle between frames.
REQ-036 i_RESET asserted during bit 8 -> all outputs 0 asynchronously, no o_Latch pulse; a fresh i_Load after release produces a complete, correct frame.

Source files
------------

// File: rtl/shift_out_driver.sv
// Serial shift-out driver for daisy-chained shift registers (e.g. 74HC595):
// clocks CHANNELS parallel lanes out on a shared SCLK, then pulses a latch strobe.
module shift_out_driver #(
    parameter int DATA_W       = 16,
    parameter int CHANNELS     = 1,
    parameter int CLK_DIV      = 4,
    parameter int MSB_FIRST    = 1,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                         i_CLK,
    input  logic                         i_RESET,
    input  logic [CHANNELS*DATA_W-1:0]   i_Data,
    input  logic                         i_Load,
    input  logic                         i_AutoRefresh,
    output logic [CHANNELS-1:0]          o_SData,
    output logic                         o_SCLK,
    output logic                         o_Latch,
    output logic                         o_Busy,
    output logic                         o_Done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t                       state_q, state_d;
    logic [CHANNELS*DATA_W-1:0]   shadow_q, shadow_d;
    logic [BIT_W-1:0]             bitCnt_q, bitCnt_d;
    logic [DIV_W-1:0]             divCnt_q, divCnt_d;
    logic [LAT_W-1:0]             latchCnt_q, latchCnt_d;
    logic                         sclkPhase_q, sclkPhase_d;
    logic                         done_q, done_d;

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            bitCnt_q    <= '0;
            divCnt_q    <= '0;
            latchCnt_q  <= '0;
            sclkPhase_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            bitCnt_q    <= bitCnt_d;
            divCnt_q    <= divCnt_d;
            latchCnt_q  <= latchCnt_d;
            sclkPhase_q <= sclkPhase_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        bitCnt_d    = bitCnt_q;
        divCnt_d    = divCnt_q;
        latchCnt_d  = latchCnt_q;
        sclkPhase_d = sclkPhase_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Load || i_AutoRefresh) begin
                    state_d     = SHIFT;
                    shadow_d    = i_Data;
                    bitCnt_d    = '0;
                    divCnt_d    = '0;
                    sclkPhase_d = 1'b0;
                end
            end

            SHIFT: begin
                if (divCnt_q == DIV_LAST) begin
                    divCnt_d    = '0;
                    sclkPhase_d = ~sclkPhase_q;
                    if (sclkPhase_q) begin
                        // The last bit is not shifted away so LATCH keeps presenting it.
                        if (bitCnt_q == BIT_LAST) begin
                            state_d     = LATCH;
                            latchCnt_d  = '0;
                            sclkPhase_d = 1'b0;
                        end else begin
                            bitCnt_d = bitCnt_q + BIT_W'(1);
                            for (int k = 0; k < CHANNELS; k++) begin
                                if (MSB_FIRST != 0)
                                    shadow_d[k*DATA_W +: DATA_W] = {shadow_q[k*DATA_W +: DATA_W-1], 1'b0};
                                else
                                    shadow_d[k*DATA_W +: DATA_W] = {1'b0, shadow_q[k*DATA_W+1 +: DATA_W-1]};
                            end
                        end
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end

            LATCH: begin
                if (latchCnt_q == LAT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    latchCnt_d = latchCnt_q + LAT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them without a clock.
    always_comb begin
        o_SData = '0;
        if (state_q != IDLE) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (MSB_FIRST != 0)
                    o_SData[k] = shadow_q[k*DATA_W + DATA_W - 1];
                else
                    o_SData[k] = shadow_q[k*DATA_W];
            end
        end
    end

    assign o_SCLK  = (state_q == SHIFT) && sclkPhase_q;
    assign o_Latch = (state_q == LATCH);
    assign o_Busy  = (state_q != IDLE);
    assign o_Done  = done_q;

endmodule

// File: tb/tb_shift_out_driver.sv
// Directed self-checking bench for shift_out_driver: a two-lane MSB-first instance
// and a single-lane LSB-first instance, both with CLK_DIV=2 and LATCH_CYCLES=2.
module tb_shift_out_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dataIn;
    logic        load;
    logic        auto;
    bit          useB;

    logic [1:0]  sdataA;
    logic        sclkA, latchA, busyA, doneA;
    logic [0:0]  sdataB;
    logic        sclkB, latchB, busyB, doneB;

    logic [1:0]  selSData;
    logic        selSclk, selLatch, selBusy, selDone;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    shift_out_driver #(
        .DATA_W(16), .CHANNELS(2), .CLK_DIV(2), .MSB_FIRST(1), .LATCH_CYCLES(2)
    ) dutA (
        .i_CLK(clock), .i_RESET(reset), .i_Data(dataIn),
        .i_Load(load && !useB), .i_AutoRefresh(auto),
        .o_SData(sdataA), .o_SCLK(sclkA), .o_Latch(latchA),
        .o_Busy(busyA), .o_Done(doneA)
    );

    shift_out_driver #(
        .DATA_W(16), .CHANNELS(1), .CLK_DIV(2), .MSB_FIRST(0), .LATCH_CYCLES(2)
    ) dutB (
        .i_CLK(clock), .i_RESET(reset), .i_Data(dataIn[15:0]),
        .i_Load(load && useB), .i_AutoRefresh(1'b0),
        .o_SData(sdataB), .o_SCLK(sclkB), .o_Latch(latchB),
        .o_Busy(busyB), .o_Done(doneB)
    );

    assign selSData = useB ? {1'b0, sdataB[0]} : sdataA;
    assign selSclk  = useB ? sclkB  : sclkA;
    assign selLatch = useB ? latchB : latchA;
    assign selBusy  = useB ? busyB  : busyA;
    assign selDone  = useB ? doneB  : doneA;

    // One comparison: count it and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start one frame on the selected instance and record what a downstream
    // shift register would see, plus the frame timing relative to the accept cycle.
    task automatic applyStimulus(input logic [31:0] data, input bit poke,
                                 output logic [15:0] cap0, output logic [15:0] cap1,
                                 output int shiftCyc, output int latchCyc,
                                 output int doneAt, output int badLatch);
        int n;
        logic prevSclk;
        logic [1:0] lastExp;
        cap0 = '0; cap1 = '0;
        shiftCyc = 0; latchCyc = 0; doneAt = -1; badLatch = 0;
        lastExp = useB ? {1'b0, data[15]} : {data[16], data[0]};
        @(negedge clock);
        dataIn = data;
        load = 1'b1;
        n = 0;
        prevSclk = 1'b0;
        while (doneAt < 0 && n < 200) begin
            @(negedge clock);
            n++;
            if (n == 1) load = 1'b0;
            if (poke && n == 10) begin
                load = 1'b1;
                dataIn = 32'hFFFF_0000;
            end
            if (poke && n == 11) load = 1'b0;
            if (selSclk && !prevSclk) begin
                cap0 = {cap0[14:0], selSData[0]};
                cap1 = {cap1[14:0], selSData[1]};
            end
            prevSclk = selSclk;
            if (selBusy && !selLatch) shiftCyc++;
            if (selLatch) begin
                latchCyc++;
                if (selSclk || selSData != lastExp) badLatch++;
            end
            if (selDone) doneAt = n;
        end
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] c0, c1;
        int sh, la, dn, bad, n, dones, idleCnt, busySeen, latchSeen;
        int doneT[3];

        reset = 1'b1; load = 1'b0; auto = 1'b0; dataIn = '0; useB = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resetOutputs", 32'({sdataA, sclkA, latchA, busyA, doneA}), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("idleOutputs", 32'({sdataA, sclkA, latchA, busyA, doneA}), 32'h0);

        // Basic frame 0x0300 on lane0
        applyStimulus(32'h5A5A_0300, 1'b0, c0, c1, sh, la, dn, bad);
        checkOutput("frame0300Lane0", 32'(c0), 32'h0300);
        checkOutput("frame0300Lane1", 32'(c1), 32'h5A5A);
        checkOutput("shiftCycles", 32'(sh), 32'd64);
        checkOutput("latchCycles", 32'(la), 32'd2);
        checkOutput("doneCycle", 32'(dn), 32'd67);
        checkOutput("latchHold", 32'(bad), 32'd0);

        // Two lanes on the same edges
        applyStimulus(32'hA5A5_0F0F, 1'b0, c0, c1, sh, la, dn, bad);
        checkOutput("dualLane0", 32'(c0), 32'h0F0F);
        checkOutput("dualLane1", 32'(c1), 32'hA5A5);
        checkOutput("dualLatchHold", 32'(bad), 32'd0);

        // Load and data change mid-frame
        applyStimulus(32'h1234_C3C3, 1'b1, c0, c1, sh, la, dn, bad);
        checkOutput("pokeLane0", 32'(c0), 32'hC3C3);
        checkOutput("pokeLane1", 32'(c1), 32'h1234);
        checkOutput("pokeDone", 32'(dn), 32'd67);
        busySeen = 0;
        repeat (5) begin
            @(negedge clock);
            if (busyA) busySeen++;
        end
        checkOutput("pokeNoSecondFrame", 32'(busySeen), 32'd0);

        // LSB-first instance
        useB = 1'b1;
        applyStimulus(32'h0000_0001, 1'b0, c0, c1, sh, la, dn, bad);
        checkOutput("lsbFirstBits", 32'(c0), 32'h8000);
        checkOutput("lsbFirstDone", 32'(dn), 32'd67);
        checkOutput("lsbLatchHold", 32'(bad), 32'd0);
        useB = 1'b0;

        // Auto refresh for three frames, with load also high on the first cycle
        @(negedge clock);
        dataIn = 32'h0000_00FF;
        auto = 1'b1; load = 1'b1;
        n = 0; dones = 0; idleCnt = 0;
        while (dones < 3 && n < 400) begin
            @(negedge clock);
            n++;
            if (n == 1) load = 1'b0;
            if (!busyA) idleCnt++;
            if (doneA) begin
                doneT[dones] = n;
                dones++;
            end
        end
        auto = 1'b0;
        checkOutput("autoDoneCount", 32'(dones), 32'd3);
        checkOutput("autoDone0", 32'(doneT[0]), 32'd67);
        checkOutput("autoDone1", 32'(doneT[1]), 32'd134);
        checkOutput("autoDone2", 32'(doneT[2]), 32'd201);
        checkOutput("autoIdleCycles", 32'(idleCnt), 32'd3);
        busySeen = 0;
        repeat (5) begin
            @(negedge clock);
            if (busyA) busySeen++;
        end
        checkOutput("autoStops", 32'(busySeen), 32'd0);

        // Reset during bit 8 (cycles 33..36; SCLK high in 35..36)
        @(negedge clock);
        dataIn = 32'hFFFF_FFFF;
        load = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clock);
            if (i == 1) load = 1'b0;
        end
        checkOutput("preResetBusySclk", 32'({busyA, sclkA, sdataA}), 32'hF);
        reset = 1'b1;
        #1;
        checkOutput("asyncResetOutputs", 32'({sdataA, sclkA, latchA, busyA, doneA}), 32'h0);
        latchSeen = 0;
        repeat (3) begin
            @(negedge clock);
            if (latchA) latchSeen++;
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (latchA || busyA) latchSeen++;
        end
        checkOutput("noLatchAfterAbort", 32'(latchSeen), 32'd0);
        applyStimulus(32'h0300_8001, 1'b0, c0, c1, sh, la, dn, bad);
        checkOutput("postResetLane0", 32'(c0), 32'h8001);
        checkOutput("postResetLane1", 32'(c1), 32'h0300);
        checkOutput("postResetDone", 32'(dn), 32'd67);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
